mips_imem_loader: RTL and testbench
===================================

Name: mips_imem_loader

Overview:
Writer side of the instruction-memory interface the single-cycle MIPS core reads from. It receives a program image as a byte stream over a valid/ready handshake and packs big-endian bytes into 32-bit words. It writes each word into the instruction RAM at consecutive word addresses. It holds the core in reset until the image is complete, then releases it.

Parameters:
ADDR_L, 64, instruction memory depth in words
ADDR_W, log2(ADDR_L), instruction memory word-address width

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction RAM write strobe, one cycle per word
mem_addr  output  ADDR_W  instruction RAM word address
mem_data  output  32  word to write
core_hold  output  1  1 = core held in reset
done  output  1  image loaded, core running
error  output  1  bad header or checksum; sticky until reset

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n); asserting it forces state HDR_HI.
- Reset output values: in_ready=1, mem_we=0, mem_addr=0, mem_data=0, core_hold=1, done=0, error=0; count, byte index and word counter cleared.
- Byte transfer: occurs on a rising edge with in_valid&&in_ready. in_data is ignored when no transfer occurs.
- Header: 2 bytes, big-endian 16-bit word count N.
- HDR_HI: on transfer, N[15:8] <= byte, go to HDR_LO.
- HDR_LO: on transfer, N[7:0] <= byte.
  - If N==0 or N>ADDR_L, go to ERROR.
  - Otherwise go to PAYLOAD with byte index 0 and word counter 0.
- PAYLOAD: first byte of each word is bits [31:24], last is [7:0]. On the 4th transfer, go to WRITE.
- WRITE: exactly one cycle, with in_ready=0, mem_we=1, mem_addr=word counter, mem_data=assembled word.
  - The 4th byte is visible in mem_data in this cycle, i.e. one cycle after it is accepted.
  - Word counter increments.
  - If the counter reaches N, go to RUN (or CSUM when enabled); otherwise return to PAYLOAD.
- mem_addr and mem_data hold their last values outside WRITE. mem_we=0 in every other state.
- RUN: core_hold=0, done=1, in_ready=0. Terminal until reset.
- ERROR: core_hold=1, error=1, in_ready=0. Terminal until reset.
- in_ready is 1 in HDR_HI, HDR_LO, PAYLOAD and CSUM, and 0 otherwise.
- Stalls: in_valid low mid-word simply pauses; no timeout.
- Boundary N==ADDR_L: last write goes to address ADDR_L-1. The counter never wraps.
- Reset mid-load: immediately go to HDR_HI with core_hold=1. RAM words already written are not cleared; a new load overwrites them.
- No read path; the core's fetch port to the RAM is independent. Writes occur only while core_hold=1.

Optional Feature:
- MIPS_IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all payload bytes (header excluded) is kept.
  - After the last WRITE, the state goes to CSUM, which accepts one byte.
  - If the byte equals the XOR, go to RUN; otherwise go to ERROR.
  - The running XOR is cleared on reset.
- Undefined: no CSUM state; WRITE of the last word goes directly to RUN; no checksum logic is synthesised.

Test Plan:
- Reset state: reset_n=0 -> in_ready=1, core_hold=1, done=0, error=0, mem_we=0.
- Single word: bytes 00 01 20 08 00 05 -> one mem_we pulse, addr 0, data 0x20080005, one cycle after byte 6. Then done=1, core_hold=0, in_ready=0.
- Full depth: N=64 with word k = k, in_valid toggled randomly -> 64 writes at addrs 0..63, data matching, then done=1. Bad headers: N=0 and N=65 -> error=1, core_hold=1, no mem_we.
- Reset mid-load: reset_n pulsed low after 2 of 3 words -> core_hold stays 1 and the state returns to HDR_HI. Reload of N=1, word 0xDEADBEEF -> addr 0 = 0xDEADBEEF, done=1.
- Checksum (macro defined): payload 12 34 56 78 with checksum 0x08 -> done=1. The same payload with checksum 0x09 -> error=1, done=0, core_hold=1.
- Backpressure: in_valid held high through WRITE -> in_ready=0 in that cycle, no byte lost or duplicated across 2 words (0x11223344, 0x55667788).

Source files
------------

// File: rtl/mips_imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the MIPS instruction-memory loader.
// The master side is the stream producer and RAM; the slave side is the loader.
interface mips_imem_loader_if #(
   parameter int ADDR_W = 6
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/mips_imem_loader.sv
// Packs a big-endian program image (16-bit word-count header + payload) into instruction RAM
// and holds the core in reset until it is loaded. Define MIPS_IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module mips_imem_loader #(
   parameter int ADDR_L = 64,
   parameter int ADDR_W = $clog2(ADDR_L)
) (
   input  logic              clock,
   input  logic              reset_n,
   mips_imem_loader_if.slave bus,
   output logic              core_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, WRITE, CSUM, RUN, ERROR} state_t;

   state_t            state_q;
   logic [15:0]       n_q;
   logic [1:0]        bidx_q;
   logic [ADDR_W:0]   wcnt_q;
   logic [23:0]       word_q;
   logic              in_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_data_q;
   logic              core_hold_q;
   logic              done_q;
   logic              error_q;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic              xfer;
   logic [15:0]       n_d;
   logic [31:0]       word_d;
   logic [ADDR_W:0]   wcnt_d;

   assign xfer   = bus.in_valid && in_ready_q;
   assign n_d    = {n_q[15:8], bus.in_data};
   assign word_d = {word_q, bus.in_data};
   assign wcnt_d = wcnt_q + (ADDR_W+1)'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= HDR_HI;
         n_q         <= '0;
         bidx_q      <= '0;
         wcnt_q      <= '0;
         word_q      <= '0;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         core_hold_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         case (state_q)
            HDR_HI: if (xfer) begin
               n_q[15:8] <= bus.in_data;
               state_q   <= HDR_LO;
            end
            HDR_LO: if (xfer) begin
               n_q <= n_d;
               if (n_d == 16'd0 || n_d > 16'(ADDR_L)) begin
                  state_q    <= ERROR;
                  in_ready_q <= 1'b0;
                  error_q    <= 1'b1;
               end else begin
                  state_q <= PAYLOAD;
                  bidx_q  <= '0;
                  wcnt_q  <= '0;
               end
            end
            PAYLOAD: if (xfer) begin
               word_q <= word_d[23:0];
               bidx_q <= bidx_q + 2'd1;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
               csum_q <= csum_q ^ bus.in_data;
`endif
               // Outputs for the WRITE cycle are registered here so the strobe lines up with the state.
               if (bidx_q == 2'd3) begin
                  state_q    <= WRITE;
                  in_ready_q <= 1'b0;
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= wcnt_q[ADDR_W-1:0];
                  mem_data_q <= word_d;
               end
            end
            WRITE: begin
               mem_we_q <= 1'b0;
               wcnt_q   <= wcnt_d;
               if (16'(wcnt_d) == n_q) begin
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                  state_q    <= CSUM;
                  in_ready_q <= 1'b1;
`else
                  state_q     <= RUN;
                  done_q      <= 1'b1;
                  core_hold_q <= 1'b0;
`endif
               end else begin
                  state_q    <= PAYLOAD;
                  in_ready_q <= 1'b1;
               end
            end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            CSUM: if (xfer) begin
               in_ready_q <= 1'b0;
               if (bus.in_data == csum_q) begin
                  state_q     <= RUN;
                  done_q      <= 1'b1;
                  core_hold_q <= 1'b0;
               end else begin
                  state_q <= ERROR;
                  error_q <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign core_hold    = core_hold_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Bench for mips_imem_loader: header table, hand-written corner sequences and random images
// checked against a stream-level model of the load protocol.
module tb_mips_imem_loader;

   localparam int ADDR_L = 64;
   localparam int ADDR_W = 6;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic core_hold, done, error;

   mips_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   mips_imem_loader #(.ADDR_L(ADDR_L)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      logic [15:0] n;
      int          words;
      bit          e_err;
      bit          e_done;
      int          e_writes;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   wr_t         got_q[$];
   wr_t         exp_q[$];
   logic [7:0]  stream[$];
   bit          exp_done, exp_err;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && bus.mem_we) begin
         got_q.push_back({bus.mem_addr, bus.mem_data});
         check("we_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
         check("we_core_held", {31'd0, core_hold}, 32'd1);
      end
   end

   // Reference: what the RAM and status must look like after the whole stream is offered.
   function automatic void model();
      int         n;
      logic [7:0] x;
      logic [31:0] w;
      wr_t        e;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      x = 8'h00;
      n = int'({stream[0], stream[1]});
      if (n == 0 || n > ADDR_L) begin
         exp_err = 1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = {stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]};
         x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         e.addr = ADDR_W'(k);
         e.data = w;
         exp_q.push_back(e);
      end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      if (stream.size() > 2 + 4*n && stream[2+4*n] == x) exp_done = 1;
      else exp_err = 1;
`else
      exp_done = 1;
`endif
   endfunction

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
      #1;
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_data", bus.mem_data, 32'd0);
      check("rst_core_hold", {31'd0, core_hold}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      got_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      int t;
      for (int i = 0; i < idle; i++) begin
         @(negedge clock);
         bus.in_valid = 1'b0;
         bus.in_data = 8'($urandom);
      end
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data = b;
      t = 0;
      while (!bus.in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic send_stream(input int idle_max);
      foreach (stream[i]) send_byte(stream[i], $urandom_range(0, idle_max));
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic settle_and_compare(input string nm);
      repeat (4) @(negedge clock);
      model();
      check({nm, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) begin
            check({nm, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check({nm, "_data"}, got_q[i].data, exp_q[i].data);
         end else begin
            checks++;
         end
      end
      check({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
      check({nm, "_error"}, {31'd0, error}, {31'd0, exp_err});
      check({nm, "_core_hold"}, {31'd0, core_hold}, {31'd0, !exp_done});
      check({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
   endtask

   task automatic push_word(input logic [31:0] w);
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endtask

   task automatic push_csum(input logic corrupt);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      stream.push_back(x);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[7];
      int   n;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      vecs[0] = '{n: 16'd0,    words: 0, e_err: 1, e_done: 0, e_writes: 0};
      vecs[1] = '{n: 16'd65,   words: 0, e_err: 1, e_done: 0, e_writes: 0};
      vecs[2] = '{n: 16'h0100, words: 0, e_err: 1, e_done: 0, e_writes: 0};
      vecs[3] = '{n: 16'hFFFF, words: 0, e_err: 1, e_done: 0, e_writes: 0};
      vecs[4] = '{n: 16'h4001, words: 0, e_err: 1, e_done: 0, e_writes: 0};
      vecs[5] = '{n: 16'd1,    words: 1, e_err: 0, e_done: 1, e_writes: 1};
      vecs[6] = '{n: 16'd3,    words: 3, e_err: 0, e_done: 1, e_writes: 3};

      // Header table
      for (int v = 0; v < 7; v++) begin
         apply_reset();
         stream.delete();
         stream.push_back(vecs[v].n[15:8]);
         stream.push_back(vecs[v].n[7:0]);
         for (int k = 0; k < vecs[v].words; k++) push_word($urandom);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
         if (vecs[v].words > 0) push_csum(1'b0);
`endif
         send_stream(1);
         repeat (4) @(negedge clock);
         check("tbl_error", {31'd0, error}, {31'd0, vecs[v].e_err});
         check("tbl_done", {31'd0, done}, {31'd0, vecs[v].e_done});
         check("tbl_core_hold", {31'd0, core_hold}, {31'd0, !vecs[v].e_done});
         check("tbl_nwrites", 32'(got_q.size()), 32'(vecs[v].e_writes));
         model();
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("tbl_data", got_q[i].data, exp_q[i].data);
      end

      // Single word: write strobe appears the cycle after the 6th byte
      apply_reset();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h20, 0);
      send_byte(8'h08, 0);
      send_byte(8'h00, 0);
      send_byte(8'h05, 0);
      bus.in_valid = 1'b0;
      @(negedge clock);
      check("sw_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check("sw_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("sw_mem_data", bus.mem_data, 32'h20080005);
      check("sw_in_ready", {31'd0, bus.in_ready}, 32'd0);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h2D, 0);
      bus.in_valid = 1'b0;
`endif
      @(negedge clock);
      check("sw_we_drop", {31'd0, bus.mem_we}, 32'd0);
      check("sw_data_hold", bus.mem_data, 32'h20080005);
      check("sw_done", {31'd0, done}, 32'd1);
      check("sw_core_hold", {31'd0, core_hold}, 32'd0);
      check("sw_in_ready_run", {31'd0, bus.in_ready}, 32'd0);

      // Full depth, word k = k, random valid gaps
      apply_reset();
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'h40);
      for (int k = 0; k < ADDR_L; k++) push_word(32'(k));
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      push_csum(1'b0);
`endif
      send_stream(2);
      settle_and_compare("full");
      check("full_last_addr", 32'(got_q[got_q.size()-1].addr), 32'(ADDR_L-1));

      // Backpressure: in_valid never drops, including through WRITE
      apply_reset();
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'h02);
      push_word(32'h11223344);
      push_word(32'h55667788);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      push_csum(1'b0);
`endif
      send_stream(0);
      settle_and_compare("bp");
      if (got_q.size() == 2) begin
         check("bp_w0", got_q[0].data, 32'h11223344);
         check("bp_w1", got_q[1].data, 32'h55667788);
      end

      // Reset after 2 of 3 words, then reload
      apply_reset();
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'h03);
      push_word(32'hCAFE0001);
      push_word(32'hCAFE0002);
      send_stream(1);
      repeat (3) @(negedge clock);
      check("mid_nwrites", 32'(got_q.size()), 32'd2);
      check("mid_hold_before", {31'd0, core_hold}, 32'd1);
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_hold", {31'd0, core_hold}, 32'd1);
      check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      check("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      got_q.delete();
      stream.delete();
      stream.push_back(8'h00);
      stream.push_back(8'h01);
      push_word(32'hDEADBEEF);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      push_csum(1'b0);
`endif
      send_stream(1);
      settle_and_compare("reload");
      if (got_q.size() > 0) begin
         check("reload_addr", 32'(got_q[0].addr), 32'd0);
         check("reload_data", got_q[0].data, 32'hDEADBEEF);
      end

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      // Checksum good and bad
      for (int c = 0; c < 2; c++) begin
         apply_reset();
         stream.delete();
         stream.push_back(8'h00);
         stream.push_back(8'h01);
         push_word(32'h12345678);
         stream.push_back(c == 0 ? 8'h08 : 8'h09);
         send_stream(1);
         settle_and_compare("csum");
         check("csum_done", {31'd0, done}, c == 0 ? 32'd1 : 32'd0);
         check("csum_error", {31'd0, error}, c == 0 ? 32'd0 : 32'd1);
      end
`endif

      // Random images, including out-of-range headers
      for (int it = 0; it < 10; it++) begin
         apply_reset();
         stream.delete();
         n = (it % 4 == 3) ? $urandom_range(65, 300) : $urandom_range(0, ADDR_L);
         stream.push_back(8'(n >> 8));
         stream.push_back(8'(n));
         if (n >= 1 && n <= ADDR_L) begin
            for (int k = 0; k < n; k++) push_word($urandom);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            push_csum($urandom_range(0, 2) == 0);
`endif
         end
         send_stream(2);
         settle_and_compare("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
